// File: rtl/text_ram_loader.sv
// -----------------------------------------------------------------------------
// text_ram_loader
//
// Accepts a byte stream of characters and control codes and turns it into
// writes into a 32x32 character text RAM. That RAM is shared with a display
// reader, so every write waits for ram_grant.
//
//   0x30-0x39 : write the digit value (0..9) at the cursor, then advance it
//   0x0A      : newline. Column goes to 0 and the row advances. No write.
//   0x08      : backspace. Step left and write CLEAR_CHAR there (ignored at col 0)
//   0x0C      : form feed. Fill all 1024 cells with CLEAR_CHAR and home the cursor
//   others    : consumed and ignored
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous reset, active low
//   in_data      command/character byte
//   in_valid     in_data valid
//   in_ready     byte accepted this cycle when in_valid is high (IDLE only)
//   ram_grant    text RAM port available to this block this cycle
//   ram_addr     text RAM address {row, col} (registered)
//   ram_din      text RAM write data (registered)
//   ram_we       text RAM write strobe (combinational on ram_grant)
//   busy         high whenever the FSM is not IDLE
//   cursor_row   current cursor row
//   cursor_col   current cursor column
// -----------------------------------------------------------------------------
module text_ram_loader #(
    parameter logic [7:0] CLEAR_CHAR = 8'h00,
    parameter int         WRAP_ROWS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ram_grant,
    output logic [9:0] ram_addr,
    output logic [7:0] ram_din,
    output logic       ram_we,
    output logic       busy,
    output logic [4:0] cursor_row,
    output logic [4:0] cursor_col
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    // Set for digit writes only. A backspace write leaves the cursor where it is.
    logic       adv_q, adv_d;

    // Row advance. With wrapping disabled the last row is sticky.
    function automatic logic [4:0] row_next(input logic [4:0] row);
        if (row != 5'd31)
            return row + 5'd1;
        else if (WRAP_ROWS != 0)
            return 5'd0;
        else
            return 5'd31;
    endfunction

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        din_d   = din_q;
        adv_d   = adv_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_data inside {[8'h30:8'h39]}) begin
                        addr_d  = {row_q, col_q};
                        din_d   = {4'h0, in_data[3:0]};
                        adv_d   = 1'b1;
                        state_d = S_WRITE;
                    end else if (in_data == 8'h0A) begin
                        col_d = 5'd0;
                        row_d = row_next(row_q);
                    end else if (in_data == 8'h08) begin
                        if (col_q != 5'd0) begin
                            col_d   = col_q - 5'd1;
                            addr_d  = {row_q, col_q - 5'd1};
                            din_d   = CLEAR_CHAR;
                            adv_d   = 1'b0;
                            state_d = S_WRITE;
                        end
                    end else if (in_data == 8'h0C) begin
                        addr_d  = 10'd0;
                        din_d   = CLEAR_CHAR;
                        row_d   = 5'd0;
                        col_d   = 5'd0;
                        state_d = S_CLEAR;
                    end
                end
            end

            S_WRITE: begin
                if (ram_grant) begin
                    state_d = S_IDLE;
                    if (adv_q) begin
                        if (col_q != 5'd31) begin
                            col_d = col_q + 5'd1;
                        end else if (row_q == 5'd31 && WRAP_ROWS == 0) begin
                            // Bottom-right corner without wrapping: the cursor stays put.
                            col_d = 5'd31;
                        end else begin
                            col_d = 5'd0;
                            row_d = row_next(row_q);
                        end
                    end
                end
            end

            S_CLEAR: begin
                // The address moves only after a granted write, so a stall skips nothing.
                if (ram_grant) begin
                    if (addr_q == 10'd1023)
                        state_d = S_IDLE;
                    else
                        addr_d = addr_q + 10'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= 5'd0;
            col_q   <= 5'd0;
            addr_q  <= 10'd0;
            din_q   <= 8'd0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            adv_q   <= adv_d;
        end
    end

    // The strobe follows the grant directly. An asynchronous reset forces IDLE,
    // which drops the strobe in the same cycle.
    assign ram_we     = (state_q != S_IDLE) && ram_grant;
    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign ram_addr   = addr_q;
    assign ram_din    = din_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule

// File: tb/tb_text_ram_loader.sv
module tb_text_ram_loader;

    localparam logic [7:0] CLR = 8'h2E;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       grant_base = 1'b1;
    logic       tog_g = 1'b0;
    logic       tog_en = 1'b0;
    logic       ram_grant;
    assign ram_grant = tog_en ? tog_g : grant_base;

    always #5 clk = ~clk;

    // dut1 wraps rows, dut0 saturates; both see identical stimulus
    logic       in_ready1, ram_we1, busy1, in_ready0, ram_we0, busy0;
    logic [9:0] ram_addr1, ram_addr0;
    logic [7:0] ram_din1, ram_din0;
    logic [4:0] row1, col1, row0, col0;

    text_ram_loader #(.CLEAR_CHAR(CLR), .WRAP_ROWS(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .ram_grant(ram_grant), .ram_addr(ram_addr1),
        .ram_din(ram_din1), .ram_we(ram_we1), .busy(busy1),
        .cursor_row(row1), .cursor_col(col1));

    text_ram_loader #(.CLEAR_CHAR(CLR), .WRAP_ROWS(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .ram_grant(ram_grant), .ram_addr(ram_addr0),
        .ram_din(ram_din0), .ram_we(ram_we0), .busy(busy0),
        .cursor_row(row0), .cursor_col(col0));

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] din;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        int         row;
        int         col;
        int         nwr;
    } vec_t;

    wr_t q1[$];
    wr_t q0[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  wr1 = 0;
    int  wr0 = 0;
    int  mrow[2];
    int  mcol[2];

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endfunction

    function automatic int row_adv(input int k, input int r);
        if (r < 31) return r + 1;
        return (k == 1) ? 0 : 31;
    endfunction

    function automatic void push(input int k, input int addr, input logic [7:0] din);
        wr_t e;
        e.addr = 10'(addr);
        e.din  = din;
        if (k == 1) q1.push_back(e);
        else        q0.push_back(e);
    endfunction

    function automatic void model_reset();
        q1.delete();
        q0.delete();
        for (int k = 0; k < 2; k++) begin
            mrow[k] = 0;
            mcol[k] = 0;
        end
    endfunction

    // Expected effect of one accepted byte on each DUT (k = WRAP_ROWS value)
    function automatic void model_accept(input logic [7:0] b);
        for (int k = 0; k < 2; k++) begin
            if (b >= 8'h30 && b <= 8'h39) begin
                push(k, mrow[k] * 32 + mcol[k], {4'h0, b[3:0]});
                if (mcol[k] < 31) begin
                    mcol[k]++;
                end else if (!(mrow[k] == 31 && k == 0)) begin
                    mcol[k] = 0;
                    mrow[k] = row_adv(k, mrow[k]);
                end
            end else if (b == 8'h0A) begin
                mcol[k] = 0;
                mrow[k] = row_adv(k, mrow[k]);
            end else if (b == 8'h08) begin
                if (mcol[k] > 0) begin
                    mcol[k]--;
                    push(k, mrow[k] * 32 + mcol[k], CLR);
                end
            end else if (b == 8'h0C) begin
                for (int a = 0; a < 1024; a++) push(k, a, CLR);
                mrow[k] = 0;
                mcol[k] = 0;
            end
        end
    endfunction

    // Sample point (falling edge): scoreboard every RAM write of both DUTs
    task automatic sample();
        wr_t e;
        @(negedge clk);
        if (ram_we1) begin
            wr1++;
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr1_unexpected: write addr %0d din %0h, required no write", ram_addr1, ram_din1);
            end else begin
                e = q1.pop_front();
                chk("wr1_addr", int'(ram_addr1), int'(e.addr));
                chk("wr1_din", int'(ram_din1), int'(e.din));
            end
        end
        if (ram_we0) begin
            wr0++;
            if (q0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr0_unexpected: write addr %0d din %0h, required no write", ram_addr0, ram_din0);
            end else begin
                e = q0.pop_front();
                chk("wr0_addr", int'(ram_addr0), int'(e.addr));
                chk("wr0_din", int'(ram_din0), int'(e.din));
            end
        end
    endtask

    // Drive point: just after the rising edge
    task automatic advance();
        @(posedge clk);
        #1;
        if (tog_en) tog_g = ~tog_g;
    endtask

    task automatic send(input logic [7:0] b);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!done) begin
            sample();
            if (in_ready1) begin
                model_accept(b);
                done = 1'b1;
            end
            advance();
            n++;
            if (!done && n > 5000) begin
                chk("send_timeout", 0, 1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            sample();
            if (!busy1 && !busy0) break;
            advance();
            n++;
            if (n > 4000) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
        advance();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        sample();
        advance();
        reset = 1'b1;
        sample();
        advance();
    endtask

    task automatic chk_cursor(input string name, input int r1, input int c1, input int r0, input int c0);
        chk({name, "_row1"}, int'(row1), r1);
        chk({name, "_col1"}, int'(col1), c1);
        chk({name, "_row0"}, int'(row0), r0);
        chk({name, "_col0"}, int'(col0), c0);
    endtask

    vec_t tbl[9];

    initial begin
        int w, w0, bad;

        tbl[0] = '{8'h31, 0, 1, 1};
        tbl[1] = '{8'h32, 0, 2, 1};
        tbl[2] = '{8'h33, 0, 3, 1};
        tbl[3] = '{8'h41, 0, 3, 0};
        tbl[4] = '{8'h08, 0, 2, 1};
        tbl[5] = '{8'h0A, 1, 0, 0};
        tbl[6] = '{8'h08, 1, 0, 0};
        tbl[7] = '{8'h39, 1, 1, 1};
        tbl[8] = '{8'h0D, 1, 1, 0};

        model_reset();
        #1 reset = 1'b0;
        advance();
        sample();
        chk("rst_we", int'(ram_we1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_addr", int'(ram_addr1), 0);
        chk("rst_din", int'(ram_din1), 0);
        chk_cursor("rst", 0, 0, 0, 0);
        advance();
        reset = 1'b1;
        sample();
        chk("rst_ready", int'(in_ready1), 1);
        chk("rst_ready0", int'(in_ready0), 1);
        advance();

        // Table: byte in, cursor and write count expected after it completes
        for (int i = 0; i < 9; i++) begin
            w = wr1;
            send(tbl[i].b);
            wait_idle();
            chk_cursor($sformatf("tbl%0d", i), tbl[i].row, tbl[i].col, tbl[i].row, tbl[i].col);
            chk($sformatf("tbl%0d_nwr", i), wr1 - w, tbl[i].nwr);
        end

        // Digit held for 5 ungranted cycles, next byte waiting upstream
        grant_base = 1'b0;
        send(8'h34);
        in_data  = 8'h0A;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("hold_we", int'(ram_we1), 0);
            chk("hold_ready", int'(in_ready1), 0);
            chk("hold_addr", int'(ram_addr1), 33);
            chk("hold_din", int'(ram_din1), 4);
            advance();
        end
        grant_base = 1'b1;
        w = wr1;
        send(8'h0A);
        wait_idle();
        chk("hold_nwr", wr1 - w, 1);
        chk_cursor("hold", 2, 0, 2, 0);

        // End of row 0 and newline
        do_reset();
        for (int i = 0; i < 31; i++) send(8'h30);
        wait_idle();
        chk_cursor("col31", 0, 31, 0, 31);
        w = wr1;
        send(8'h35);
        wait_idle();
        chk_cursor("eol", 1, 0, 1, 0);
        chk("eol_nwr", wr1 - w, 1);
        w = wr1;
        send(8'h0A);
        wait_idle();
        chk_cursor("nl", 2, 0, 2, 0);
        chk("nl_nwr", wr1 - w, 0);

        // Bottom-right corner, wrapping vs saturating
        do_reset();
        for (int i = 0; i < 31; i++) send(8'h0A);
        for (int i = 0; i < 31; i++) send(8'h31);
        wait_idle();
        chk_cursor("corner", 31, 31, 31, 31);
        send(8'h37);
        wait_idle();
        chk_cursor("corner_wr", 0, 0, 31, 31);
        send(8'h0A);
        wait_idle();
        chk_cursor("corner_nl", 1, 0, 31, 0);
        chk("q_empty_a", q1.size() + q0.size(), 0);

        // Full clear with grant toggling every cycle
        tog_en = 1'b1;
        w = wr1;
        w0 = wr0;
        bad = 0;
        send(8'h0C);
        for (int n = 0; n < 3000; n++) begin
            sample();
            if (!busy1 && !busy0) break;
            if (wr1 - w < 1024 && (!busy1 || in_ready1 || in_ready0)) bad++;
            advance();
        end
        advance();
        tog_en = 1'b0;
        chk("clr_busy_ready", bad, 0);
        chk("clr_nwr1", wr1 - w, 1024);
        chk("clr_nwr0", wr0 - w0, 1024);
        chk_cursor("clr", 0, 0, 0, 0);
        chk("q_empty_b", q1.size() + q0.size(), 0);

        // Reset in the middle of a clear
        grant_base = 1'b1;
        send(8'h31);
        w = wr1;
        send(8'h0C);
        for (int n = 0; n < 1000; n++) begin
            sample();
            if (wr1 - w >= 301) break;
            advance();
        end
        advance();
        reset = 1'b0;
        model_reset();
        sample();
        chk("abort_we1", int'(ram_we1), 0);
        chk("abort_we0", int'(ram_we0), 0);
        chk("abort_addr", int'(ram_addr1), 0);
        chk("abort_busy", int'(busy1), 0);
        advance();
        for (int i = 0; i < 2; i++) begin
            sample();
            advance();
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            advance();
        end
        chk("abort_ready", int'(in_ready1), 1);
        chk("abort_nwr", wr1 - w, 301);
        chk_cursor("abort", 0, 0, 0, 0);

        // Normal operation resumes after the abort
        send(8'h32);
        wait_idle();
        chk_cursor("post", 0, 1, 0, 1);
        chk("q_empty_c", q1.size() + q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
